sd_ram_bridge: RTL and testbench

- Sits directly downstream of the SD-card block loader; consumes its word-write interface (ram_we/ram_address/ram_data) and returns the ram_op_begun acknowledge.
- Converts each word into an Avalon-MM master transaction to the SDRAM controller.
- Once loading completes, the same master port serves single-word reads for the audio playback stage.
- Holds one transaction at a time and times out a stalled bus.

---
 rtl/sd_ram_bridge_pkg.sv | 25 ++
 rtl/sd_ram_bridge_if.sv | 24 ++
 rtl/sd_ram_bridge_wait_timer.sv | 46 ++++
 rtl/sd_ram_bridge.sv | 136 +++++++++++++
 tb/tb_sd_ram_bridge.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_ram_bridge_pkg.sv
// Shared types and constants for the SD-loader to Avalon-MM SDRAM bridge.
package sd_ram_bridge_pkg;

  localparam int AVM_AW  = 26;
  localparam int WORD_AW = 25;
  localparam int DATA_W  = 16;

  localparam logic [1:0] BYTE_EN_ALL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WACK,
    ST_RD,
    ST_RWAIT,
    ST_ERR
  } bridge_state_t;

  // Word address to byte address; the sum wraps at 2^26.
  function automatic logic [AVM_AW-1:0] word_to_byte(input logic [AVM_AW-1:0]  base,
                                                     input logic [WORD_AW-1:0] word);
    return base + {word, 1'b0};
  endfunction

endpackage

// File: rtl/sd_ram_bridge_if.sv
// Avalon-MM master/slave bundle between the bridge and the SDRAM controller.
interface sd_ram_bridge_if;
  import sd_ram_bridge_pkg::*;

  logic [AVM_AW-1:0] avm_address;
  logic              avm_write;
  logic              avm_read;
  logic [DATA_W-1:0] avm_writedata;
  logic [1:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    output avm_address, avm_write, avm_read, avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_write, avm_read, avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );

endinterface

// File: rtl/sd_ram_bridge_wait_timer.sv
// Wait-state watchdog: counts cycles while enabled, clear wins over enable.
// expired is high from the TERMINAL-th enabled cycle on (TERMINAL >= 2).
module sd_ram_bridge_wait_timer #(
  parameter int unsigned TERMINAL = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TERMINAL + 1);
  localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          expired_q, expired_d;

  assign cnt_inc = cnt_q + 1'b1;

  // Flag is registered one cycle early so the FSM can leave on the terminal cycle.
  always_comb begin
    cnt_d     = cnt_q;
    expired_d = expired_q;
    if (clr) begin
      cnt_d     = '0;
      expired_d = 1'b0;
    end else if (en) begin
      if (cnt_q != LAST) cnt_d = cnt_inc;
      if (cnt_inc == LAST) expired_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/sd_ram_bridge.sv
// Turns SD-loader word writes, then playback single-word reads, into
// one-at-a-time Avalon-MM transactions with a wait-state timeout.
module sd_ram_bridge
  import sd_ram_bridge_pkg::*;
#(
  parameter logic [AVM_AW-1:0] AVM_BASE       = 26'h0000000,
  parameter int unsigned       TIMEOUT_CYCLES = 1023
) (
  input  logic               clk50,
  input  logic               reset_n,
  input  logic               ram_we,
  input  logic [WORD_AW-1:0] ram_address,
  input  logic [DATA_W-1:0]  ram_data,
  output logic               ram_op_begun,
  input  logic               init_done,
  input  logic               rd_req,
  input  logic [WORD_AW-1:0] rd_address,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               rd_busy,
  output logic               rd_overrun,
  output logic               bus_error,
  sd_ram_bridge_if.master    avm
);

  bridge_state_t     state_q, state_d;
  logic [AVM_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overrun_q, overrun_d;
  logic              bus_error_q, bus_error_d;
  logic              tmr_clr, tmr_en, tmr_expired;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    bus_error_d = bus_error_q;
    // A read is lost if busy, before init, or colliding with a loader write.
    overrun_d   = overrun_q |
                  (rd_req & ((state_q != ST_IDLE) | ~init_done | ram_we));

    unique case (state_q)
      ST_IDLE: begin
        if (ram_we) begin
          addr_d  = word_to_byte(AVM_BASE, ram_address);
          wdata_d = ram_data;
          state_d = ST_WR;
        end else if (rd_req && init_done) begin
          addr_d  = word_to_byte(AVM_BASE, rd_address);
          state_d = ST_RD;
        end
      end
      ST_WR: begin
        if (!avm.avm_waitrequest) begin
          state_d = ST_WACK;
        end else if (tmr_expired) begin
          state_d     = ST_ERR;
          bus_error_d = 1'b1;
        end
      end
      ST_WACK: state_d = ST_IDLE;
      ST_RD: begin
        if (!avm.avm_waitrequest) begin
          state_d = ST_RWAIT;
        end else if (tmr_expired) begin
          state_d     = ST_ERR;
          bus_error_d = 1'b1;
        end
      end
      ST_RWAIT: begin
        if (avm.avm_readdatavalid) begin
          rd_data_d  = avm.avm_readdata;
          rd_valid_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (tmr_expired) begin
          state_d     = ST_ERR;
          bus_error_d = 1'b1;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overrun_q   <= overrun_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Any state change restarts the count, so each wait state gets a full budget.
  assign tmr_clr = (state_d != state_q);
  assign tmr_en  = (state_q == ST_WR) || (state_q == ST_RD) || (state_q == ST_RWAIT);

  sd_ram_bridge_wait_timer #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk50),
    .rst_n   (reset_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  assign avm.avm_address    = addr_q;
  assign avm.avm_writedata  = wdata_q;
  assign avm.avm_write      = (state_q == ST_WR);
  assign avm.avm_read       = (state_q == ST_RD);
  assign avm.avm_byteenable = BYTE_EN_ALL;

  assign ram_op_begun = (state_q == ST_WACK);
  assign rd_busy      = (state_q != ST_IDLE);
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign rd_overrun   = overrun_q;
  assign bus_error    = bus_error_q;

endmodule

// File: tb/tb_sd_ram_bridge.sv
// Self-checking bench for sd_ram_bridge: vector table, scoreboard queues,
// plus hand sequences for drops, async reset and bus timeout.
module tb_sd_ram_bridge;

  logic        clk50 = 1'b0;
  logic        reset_n = 1'b1;
  logic        ram_we = 1'b0;
  logic [24:0] ram_address = '0;
  logic [15:0] ram_data = '0;
  logic        ram_op_begun;
  logic        init_done = 1'b0;
  logic        rd_req = 1'b0;
  logic [24:0] rd_address = '0;
  logic [15:0] rd_data;
  logic        rd_valid, rd_busy, rd_overrun, bus_error;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [41:0] wr_q[$];
  logic [25:0] ra_q[$];
  logic [15:0] rd_q[$];

  sd_ram_bridge_if bus ();

  always #10 clk50 = ~clk50;

  sd_ram_bridge #(
    .AVM_BASE       (26'h0000000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk50        (clk50),
    .reset_n      (reset_n),
    .ram_we       (ram_we),
    .ram_address  (ram_address),
    .ram_data     (ram_data),
    .ram_op_begun (ram_op_begun),
    .init_done    (init_done),
    .rd_req       (rd_req),
    .rd_address   (rd_address),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_busy      (rd_busy),
    .rd_overrun   (rd_overrun),
    .bus_error    (bus_error),
    .avm          (bus)
  );

  typedef struct {
    bit          is_rd;
    bit          init;
    logic [24:0] addr;
    logic [15:0] data;
    int unsigned stall;
    logic [25:0] exp_addr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk50);
    reset_n = 1'b0;
    ram_we = 1'b0; rd_req = 1'b0; init_done = 1'b0;
    bus.avm_waitrequest = 1'b0; bus.avm_readdatavalid = 1'b0;
    #5;
    @(negedge clk50);
    reset_n = 1'b1;
  endtask

  task automatic do_write(input logic [24:0] a, input logic [15:0] d, input int unsigned stall,
                          input logic [25:0] exp_addr, input bit init, input bit with_rd);
    int unsigned wcyc = 0;
    int unsigned ack_k = 0;
    logic [41:0] exp;
    logic [41:0] popped;
    @(negedge clk50);
    init_done = init; ram_we = 1'b1; ram_address = a; ram_data = d;
    rd_req = with_rd; rd_address = 25'h0AAAA; bus.avm_waitrequest = 1'b0;
    exp = {exp_addr, d};
    wr_q.push_back(exp);
    for (int unsigned k = 1; k <= 40 && ack_k == 0; k++) begin
      @(negedge clk50);
      rd_req = 1'b0;
      if (bus.avm_write) begin
        wcyc++;
        check("wr_addr_data_stable", 32'({bus.avm_address, bus.avm_writedata} == exp), 32'd1);
        if (k <= stall) bus.avm_waitrequest = 1'b1;
        else begin
          bus.avm_waitrequest = 1'b0;
          if (wr_q.size() == 0) check("wr_scoreboard_empty", 32'd1, 32'd0);
          else begin
            popped = wr_q.pop_front();
            check("wr_addr", 32'(bus.avm_address), 32'(popped[41:16]));
            check("wr_data", 32'(bus.avm_writedata), 32'(popped[15:0]));
            check("wr_byteenable", 32'(bus.avm_byteenable), 32'h3);
          end
        end
      end else bus.avm_waitrequest = 1'b0;
      if (ram_op_begun) begin
        ack_k = k;
        ram_we = 1'b0;
      end
    end
    ram_we = 1'b0;
    check("wr_strobe_cycles", 32'(wcyc), 32'(stall + 1));
    check("wr_ack_latency", 32'(ack_k), 32'(stall + 2));
    @(negedge clk50);
    check("wr_ack_single_pulse", 32'(ram_op_begun), 32'd0);
    check("wr_idle_after", 32'(rd_busy), 32'd0);
  endtask

  task automatic do_read(input logic [24:0] a, input logic [15:0] d, input int unsigned stall,
                         input logic [25:0] exp_addr, input bit poke);
    int unsigned rcyc = 0;
    int unsigned acc_k = 0;
    bit got = 1'b0;
    logic [25:0] pa;
    logic [15:0] pd;
    @(negedge clk50);
    init_done = 1'b1; ram_we = 1'b0; rd_req = 1'b1; rd_address = a;
    bus.avm_waitrequest = 1'b0;
    ra_q.push_back(exp_addr);
    rd_q.push_back(d);
    for (int unsigned k = 1; k <= 60 && !got; k++) begin
      @(negedge clk50);
      rd_req = 1'b0;
      bus.avm_readdatavalid = 1'b0;
      if (rd_valid) begin
        got = 1'b1;
        if (rd_q.size() == 0) check("rd_scoreboard_empty", 32'd1, 32'd0);
        else begin
          pd = rd_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(pd));
        end
        check("rd_busy_at_valid", 32'(rd_busy), 32'd0);
      end else begin
        if (bus.avm_read) begin
          rcyc++;
          if (k <= stall) begin
            bus.avm_waitrequest = 1'b1;
            // stray return strobe while still in RD must be ignored
            bus.avm_readdata = 16'hDEAD;
            bus.avm_readdatavalid = 1'b1;
          end else begin
            bus.avm_waitrequest = 1'b0;
            acc_k = k;
            if (ra_q.size() == 0) check("rd_scoreboard_empty", 32'd1, 32'd0);
            else begin
              pa = ra_q.pop_front();
              check("rd_addr", 32'(bus.avm_address), 32'(pa));
            end
          end
        end else bus.avm_waitrequest = 1'b0;
        if (acc_k != 0 && k == acc_k + 3) begin
          bus.avm_readdata = d;
          bus.avm_readdatavalid = 1'b1;
        end
        if (poke && acc_k != 0 && k == acc_k + 1) rd_req = 1'b1;
      end
    end
    bus.avm_readdatavalid = 1'b0;
    check("rd_completed", 32'(got), 32'd1);
    check("rd_strobe_cycles", 32'(rcyc), 32'(stall + 1));
    @(negedge clk50);
    check("rd_valid_single_pulse", 32'(rd_valid), 32'd0);
    check("rd_busy_after", 32'(rd_busy), 32'd0);
    check("rd_data_held", 32'(rd_data), 32'(d));
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int unsigned wcyc, ack, err_k;

    vecs[0] = '{0, 0, 25'h0000010, 16'hBEEF, 0, 26'h0000020};
    vecs[1] = '{0, 0, 25'h0000123, 16'hA5A5, 5, 26'h0000246};
    vecs[2] = '{0, 0, 25'h1FFFFFF, 16'h0001, 2, 26'h3FFFFFE};
    vecs[3] = '{1, 1, 25'h01FFFFF, 16'h1234, 0, 26'h03FFFFE};
    vecs[4] = '{1, 1, 25'h0000000, 16'hCAFE, 3, 26'h0000000};
    vecs[5] = '{0, 1, 25'h00ABCDE, 16'h5A5A, 1, 26'h01579BC};

    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata = '0;
    bus.avm_readdatavalid = 1'b0;

    #2 reset_n = 1'b0;
    #5;
    check("rst_avm_write", 32'(bus.avm_write), 32'd0);
    check("rst_avm_read", 32'(bus.avm_read), 32'd0);
    check("rst_ram_op_begun", 32'(ram_op_begun), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_busy", 32'(rd_busy), 32'd0);
    check("rst_rd_overrun", 32'(rd_overrun), 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_avm_address", 32'(bus.avm_address), 32'd0);
    check("rst_byteenable", 32'(bus.avm_byteenable), 32'h3);
    @(negedge clk50);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].is_rd)
        do_read(vecs[i].addr, vecs[i].data, vecs[i].stall, vecs[i].exp_addr, 1'b0);
      else
        do_write(vecs[i].addr, vecs[i].data, vecs[i].stall, vecs[i].exp_addr, vecs[i].init, 1'b0);
    end
    check("table_no_overrun", 32'(rd_overrun), 32'd0);
    check("table_no_bus_error", 32'(bus_error), 32'd0);

    // rd_req before init_done is dropped
    reset_dut();
    @(negedge clk50);
    init_done = 1'b0; rd_req = 1'b1; rd_address = 25'h10;
    @(negedge clk50);
    rd_req = 1'b0;
    check("drop_noinit_overrun", 32'(rd_overrun), 32'd1);
    check("drop_noinit_busy", 32'(rd_busy), 32'd0);
    check("drop_noinit_no_read", 32'(bus.avm_read), 32'd0);

    // rd_req together with ram_we: write proceeds, read dropped
    reset_dut();
    do_write(25'h0000040, 16'h7777, 0, 26'h0000080, 1'b1, 1'b1);
    check("drop_collide_overrun", 32'(rd_overrun), 32'd1);

    // rd_req while RWAIT: dropped, in-flight read still completes
    reset_dut();
    do_read(25'h0000055, 16'h9999, 1, 26'h00000AA, 1'b1);
    check("drop_rwait_overrun", 32'(rd_overrun), 32'd1);

    // async reset while in RWAIT, with overrun and rd_data non-zero
    @(negedge clk50);
    init_done = 1'b1; rd_req = 1'b1; rd_address = 25'h10; bus.avm_waitrequest = 1'b0;
    @(negedge clk50);
    rd_req = 1'b0;
    check("rstmid_in_rd", 32'(bus.avm_read), 32'd1);
    @(negedge clk50);
    check("rstmid_rwait_busy", 32'(rd_busy), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("rstmid_avm_read", 32'(bus.avm_read), 32'd0);
    check("rstmid_busy", 32'(rd_busy), 32'd0);
    check("rstmid_overrun", 32'(rd_overrun), 32'd0);
    check("rstmid_rd_data", 32'(rd_data), 32'd0);
    check("rstmid_rd_valid", 32'(rd_valid), 32'd0);
    check("rstmid_bus_error", 32'(bus_error), 32'd0);
    check("rstmid_avm_address", 32'(bus.avm_address), 32'd0);
    @(negedge clk50);
    reset_n = 1'b1;

    // async reset while read strobe is stalled in RD
    @(negedge clk50);
    init_done = 1'b1; rd_req = 1'b1; rd_address = 25'h22; bus.avm_waitrequest = 1'b1;
    @(negedge clk50);
    rd_req = 1'b0;
    check("rstrd_strobe_up", 32'(bus.avm_read), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("rstrd_strobe_dropped", 32'(bus.avm_read), 32'd0);
    check("rstrd_no_ack", 32'(ram_op_begun), 32'd0);
    bus.avm_waitrequest = 1'b0;
    @(negedge clk50);
    reset_n = 1'b1;
    do_write(vecs[0].addr, vecs[0].data, 0, vecs[0].exp_addr, 1'b0, 1'b0);

    // timeout: waitrequest stuck high
    reset_dut();
    @(negedge clk50);
    init_done = 1'b0; ram_we = 1'b1; ram_address = 25'h3; ram_data = 16'h1111;
    bus.avm_waitrequest = 1'b1;
    wcyc = 0; ack = 0; err_k = 0;
    for (int unsigned k = 1; k <= 40 && err_k == 0; k++) begin
      @(negedge clk50);
      if (bus.avm_write) wcyc++;
      if (ram_op_begun) ack++;
      if (bus_error) err_k = k;
    end
    check("to_strobe_cycles", 32'(wcyc), 32'd16);
    check("to_error_cycle", 32'(err_k), 32'd17);
    check("to_write_low", 32'(bus.avm_write), 32'd0);
    check("to_read_low", 32'(bus.avm_read), 32'd0);
    bus.avm_waitrequest = 1'b0;
    repeat (6) begin
      @(negedge clk50);
      if (ram_op_begun) ack++;
    end
    check("to_no_ack", 32'(ack), 32'd0);
    check("to_stuck_busy", 32'(rd_busy), 32'd1);
    check("to_sticky_error", 32'(bus_error), 32'd1);
    check("to_stuck_no_write", 32'(bus.avm_write), 32'd0);
    ram_we = 1'b0;
    check("sb_wr_drained", 32'(wr_q.size()), 32'd0);
    check("sb_rd_drained", 32'(rd_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
